serial_load_ctrl: RTL and testbench
===================================

# serial_load_ctrl

Sequencer for the 7-bit serial-in/parallel-out shift register. It accepts a parallel 7-bit word through a valid/ready handshake and drives it bit-serially into the register's `in` pin, LSB first. Once all bits have landed, it samples the register's parallel output into a held word and pulses `done`. It sits between a word producer (display/encoder logic) and the shift register, and it shares `clk` and `reset` with that register.

## Interface
- `WIDTH`, default 7: word length; must equal the shift-register depth.
- `IDLE_BIT`, default 1'b0: value driven on `ser_out` whenever no word is shifting.

Ports:
- `clk`, input, 1: rising-edge clock shared with the shift register.
- `reset`, input, 1: asynchronous, active-high; shared with the shift register.
- `load_valid`, input, 1: producer offers `load_data`.
- `load_data`, input, WIDTH: word to serialize.
- `load_ready`, output, 1: controller can accept a word this cycle.
- `ser_out`, output, 1: drives the shift register's `in`.
- `par_in`, input, WIDTH: the shift register's `out[6:0]`.
- `held`, output, WIDTH: last captured register word.
- `done`, output, 1: one-cycle pulse; `held` was updated on the previous edge.
- `busy`, output, 1: high in SHIFT or CAPTURE.
- `err`, output, 1: sticky; a captured word differed from the word sent.

## Operation
- **States:** IDLE, SHIFT, CAPTURE.
- **Internal registers:**
  - `shreg[WIDTH-1:0]`
  - `sent[WIDTH-1:0]`, a copy of the accepted word
  - `cnt[2:0]`
- **Handshake:** a word is accepted on an edge where `load_valid && load_ready`. `load_data` is sampled on that edge only. Holding `load_valid` without `load_ready` has no effect.
- **`load_ready`:** 1 in IDLE and CAPTURE, 0 in SHIFT.
- **IDLE:**
  - `ser_out = IDLE_BIT`.
  - On accept: `shreg <= load_data`, `sent <= load_data`, `cnt <= 0`, go to SHIFT.
- **SHIFT:**
  - `ser_out = shreg[0]`.
  - Each edge: `shreg <= shreg >> 1` and `cnt <= cnt + 1`.
  - On the edge where `cnt == WIDTH-1`, go to CAPTURE.
- **CAPTURE:**
  - `ser_out = IDLE_BIT`.
  - The register now holds the word: first bit sent is at `par_in[0]`, last at `par_in[6]`, so `par_in == sent`.
  - On the next edge: `held <= par_in`, `done <= 1`, and `err <= err | (par_in != sent)`.
  - If an accept occurs on the same edge, load as from IDLE and go to SHIFT (back-to-back). Otherwise go to IDLE.
- **`done`:** registered; high for exactly one cycle after the CAPTURE edge.
- **`cnt`:** never wraps in SHIFT; it is reset on each accept.

## Timing
- **Reset values** (async, immediate on `reset`):
  - state = IDLE, `shreg = 0`, `sent = 0`, `cnt = 0`
  - `held = 0`, `done = 0`, `err = 0`, `busy = 0`
  - `load_ready = 1`, `ser_out = IDLE_BIT`
- **Latency:** accept edge E0 → bit `k` is on `ser_out` during the cycle after edge E(k) → register is complete after E7 → `held` updated at E8 → `done` high in the cycle after E8.
- **Throughput:** one word per WIDTH+1 = 8 cycles with `load_valid` held high.
- `ser_out` changes only just after rising edges, so it is stable at the register's sampling edge.
- **Reset mid-SHIFT:** the partial word is discarded and the register is cleared too (shared reset). No `done` is issued and `err` is not set.
- **Simultaneous CAPTURE and accept:** capture uses `par_in` before new bits shift in, because the first new bit enters at the following edge. Both actions complete.
- **Feedback path:** `par_in` is sampled only in CAPTURE. There is no combinational path from `par_in` to any output.

## Structure
- **Shared include file** holds:
  - state encoding localparams: `ST_IDLE = 2'd0`, `ST_SHIFT = 2'd1`, `ST_CAPTURE = 2'd2`
  - the default `WIDTH = 7`
- **Implementation:** a single module with no sub-module. It is instantiated beside the shift register at the level above: `ser_out` → `in`, `out` → `par_in`, shared `clk`/`reset`.
- **Unused encoding `2'd3`:** returns to IDLE.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs at reset values immediately; `load_ready = 1`, `held = 7'h00`.
- **Single word:** accept `7'b1011001` → `ser_out` sequence 1,0,0,1,1,0,1 over 7 cycles; `held = 7'b1011001` at E8; `done` is one cycle high; `err = 0`.
- **Back-to-back:** `load_valid` high with words `7'h55` then `7'h2A`:
  - second word accepted at E8;
  - `held` = `7'h55` then `7'h2A`;
  - `done` pulses exactly 8 cycles apart.
- **Stall:** `load_valid` high during SHIFT with changing `load_data` → ignored; the captured word equals the original.
- **Reset mid-SHIFT:** reset after 3 bits → no `done`; next word `7'h7F` captures correctly.
- **Corrupted feedback:** force `par_in[3]` inverted during CAPTURE → `err` goes to 1 and stays 1 across later good words until `reset`.

Source files
------------

// File: rtl/serial_load_ctrl_pkg.sv
// Shared definitions for the serial load controller: default word width and state encoding.
package serial_load_ctrl_pkg;

   localparam int unsigned DEF_WIDTH = 7;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_SHIFT   = ST_SHIFT,
      S_CAPTURE = ST_CAPTURE,
      S_UNUSED  = 2'd3
   } state_t;

endpackage

// File: rtl/serial_load_ctrl.sv
// Sequencer that serializes a parallel word LSB-first into a SIPO shift register,
// then captures the register's parallel output and checks it against the word sent.
module serial_load_ctrl
   import serial_load_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter logic        IDLE_BIT = 1'b0
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   input  logic [WIDTH-1:0] par_in,
   output logic [WIDTH-1:0] held,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int unsigned      CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_sent;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_held;
   logic             r_done;
   logic             r_err;
   logic             r_ready;
   logic             r_ser;
   logic             r_busy;

   logic [WIDTH-1:0] w_shreg_nxt;
   logic [WIDTH-1:0] w_sent_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_held_nxt;
   logic             w_done_nxt;
   logic             w_err_nxt;

   // Next-state and next-datapath values; accept only happens in IDLE or CAPTURE.
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_sent_nxt  = r_sent;
      w_cnt_nxt   = r_cnt;
      w_held_nxt  = r_held;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;

      case (r_state)
         S_IDLE: begin
            if (load_valid) begin
               w_shreg_nxt = load_data;
               w_sent_nxt  = load_data;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_shreg_nxt = r_shreg >> 1;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            // par_in still holds the finished word; a new first bit only lands next edge
            w_held_nxt = par_in;
            w_done_nxt = 1'b1;
            w_err_nxt  = r_err | (par_in != r_sent);
            if (load_valid) begin
               w_shreg_nxt = load_data;
               w_sent_nxt  = load_data;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered outputs, derived from the upcoming state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg <= '0;
         r_sent  <= '0;
         r_cnt   <= '0;
         r_held  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_ready <= 1'b1;
         r_ser   <= IDLE_BIT;
         r_busy  <= 1'b0;
      end else begin
         r_shreg <= w_shreg_nxt;
         r_sent  <= w_sent_nxt;
         r_cnt   <= w_cnt_nxt;
         r_held  <= w_held_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_ready <= (w_state_nxt != S_SHIFT);
         r_busy  <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CAPTURE);
         r_ser   <= (w_state_nxt == S_SHIFT) ? w_shreg_nxt[0] : IDLE_BIT;
      end
   end

   assign load_ready = r_ready;
   assign ser_out    = r_ser;
   assign held       = r_held;
   assign done       = r_done;
   assign busy       = r_busy;
   assign err        = r_err;

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Self-checking bench: controller driving a behavioural 7-bit SIPO register.
module tb_serial_load_ctrl;

   localparam int unsigned W = 7;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic         ser_out;
   logic [W-1:0] par_in;
   logic [W-1:0] held;
   logic         done;
   logic         busy;
   logic         err;

   logic [W-1:0] sr;
   logic [W-1:0] corrupt_mask;

   int n_total = 0;
   int n_pass  = 0;
   bit err_exp = 1'b0;

   always #5 clk = ~clk;

   // Shift register: new bit enters at the top, so the first bit sent ends at bit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= {ser_out, sr[W-1:1]};
   end

   assign par_in = sr ^ corrupt_mask;

   serial_load_ctrl #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ser_out    (ser_out),
      .par_in     (par_in),
      .held       (held),
      .done       (done),
      .busy       (busy),
      .err        (err)
   );

   // One word end to end; starts just after a rising edge with the controller idle.
   task automatic test_word(input logic [W-1:0] w, input logic [W-1:0] cmask, input bit stall);
      logic [W-1:0] exp_held;
      load_valid = 1'b1;
      load_data  = w;
      @(posedge clk); #1;
      if (!stall) load_valid = 1'b0;
      for (int k = 0; k < int'(W); k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (stall) load_data = W'($urandom);
         if (k == int'(W) - 1) load_valid = 1'b0;
         n_total++;
         if (ser_out !== ((w >> k) & 1)) $display("FAIL word_bit%0d w=%h got=%b exp=%b", k, w, ser_out, (w >> k) & 1);
         else n_pass++;
         if (k == 3) begin
            n_total++;
            if ({busy, load_ready, done} !== 3'b100)
               $display("FAIL shift_flags got busy/ready/done=%b exp=100", {busy, load_ready, done});
            else n_pass++;
         end
      end
      @(posedge clk); #1;
      corrupt_mask = cmask;
      n_total++;
      if ({ser_out, busy, load_ready, done} !== 4'b0110)
         $display("FAIL capture_flags got ser/busy/ready/done=%b exp=0110", {ser_out, busy, load_ready, done});
      else n_pass++;
      @(posedge clk); #1;
      corrupt_mask = '0;
      if (cmask != '0) err_exp = 1'b1;
      exp_held = w ^ cmask;
      n_total++;
      if (held !== exp_held) $display("FAIL held got=%h exp=%h", held, exp_held);
      else n_pass++;
      n_total++;
      if ({done, err, busy} !== {1'b1, err_exp, 1'b0})
         $display("FAIL done_err got done/err/busy=%b exp=%b", {done, err, busy}, {1'b1, err_exp, 1'b0});
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0) $display("FAIL done_pulse got=%b exp=0", done);
      else n_pass++;
   endtask

   // Asynchronous reset asserted mid-cycle while a word is shifting.
   task automatic test_reset();
      load_valid = 1'b1;
      load_data  = W'($urandom);
      @(posedge clk); #1;
      load_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      err_exp = 1'b0;
      n_total++;
      if ({load_ready, busy, done, err, ser_out} !== 5'b10000)
         $display("FAIL reset_flags got ready/busy/done/err/ser=%b exp=10000", {load_ready, busy, done, err, ser_out});
      else n_pass++;
      n_total++;
      if (held !== 7'h00) $display("FAIL reset_held got=%h exp=00", held);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      test_word(7'b1011001, '0, 1'b0);
      for (int i = 0; i < 5; i++) test_word(W'($urandom), '0, 1'b0);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) test_word(W'($urandom), '0, 1'b1);
   endtask

   // load_valid held high across several words; each accept advances to the next word.
   task automatic test_back_to_back();
      logic [W-1:0] words [4];
      int acc_cyc [$];
      int done_cyc [$];
      logic [W-1:0] held_seen [$];
      int idx = 0;
      int cyc = 0;
      bit acc;
      int n;
      words[0] = 7'h55;
      words[1] = 7'h2A;
      words[2] = W'($urandom);
      words[3] = W'($urandom);
      load_valid = 1'b1;
      load_data  = words[0];
      for (int c = 0; c < 80; c++) begin
         if (idx == 4 && done_cyc.size() == 4) break;
         acc = load_valid && load_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            acc_cyc.push_back(cyc);
            idx++;
            if (idx < 4) load_data = words[idx];
            else load_valid = 1'b0;
         end
         if (done) begin
            done_cyc.push_back(cyc);
            held_seen.push_back(held);
         end
      end
      load_valid = 1'b0;
      n_total++;
      if (acc_cyc.size() != 4 || done_cyc.size() != 4)
         $display("FAIL b2b_counts got acc=%0d done=%0d exp=4/4", acc_cyc.size(), done_cyc.size());
      else n_pass++;
      n = (done_cyc.size() < acc_cyc.size()) ? done_cyc.size() : acc_cyc.size();
      for (int i = 0; i < n; i++) begin
         n_total++;
         if (done_cyc[i] != acc_cyc[i] + 8) $display("FAIL b2b_latency%0d got=%0d exp=%0d", i, done_cyc[i], acc_cyc[i] + 8);
         else n_pass++;
         n_total++;
         if (held_seen[i] !== words[i]) $display("FAIL b2b_held%0d got=%h exp=%h", i, held_seen[i], words[i]);
         else n_pass++;
         if (i > 0) begin
            n_total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 8) $display("FAIL b2b_spacing%0d got=%0d exp=8", i, acc_cyc[i] - acc_cyc[i-1]);
            else n_pass++;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Reset after three bits: no done afterwards, and the next word goes through cleanly.
   task automatic test_reset_mid_shift();
      bit saw_done = 1'b0;
      load_valid = 1'b1;
      load_data  = W'($urandom);
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      err_exp = 1'b0;
      #1;
      n_total++;
      if ({busy, load_ready, done} !== 3'b010 || held !== '0)
         $display("FAIL midreset got busy/ready/done=%b held=%h exp=010/00", {busy, load_ready, done}, held);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      n_total++;
      if (saw_done !== 1'b0) $display("FAIL midreset_done got=%b exp=0", saw_done);
      else n_pass++;
      test_word(7'h7F, '0, 1'b0);
   endtask

   // Bit 3 of the feedback inverted during one capture; err must stay set until reset.
   task automatic test_corrupt();
      test_word(W'($urandom), 7'h08, 1'b0);
      test_word(W'($urandom), '0, 1'b0);
      test_word(W'($urandom), '0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      err_exp = 1'b0;
      #1;
      n_total++;
      if (err !== 1'b0) $display("FAIL corrupt_clear got=%b exp=0", err);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      test_word(W'($urandom), '0, 1'b0);
   endtask

   initial begin
      reset        = 1'b1;
      load_valid   = 1'b0;
      load_data    = '0;
      corrupt_mask = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid_shift();
      test_corrupt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
